// File: rtl/src_buf_pkg.sv
// Shared types and default sizing for the ping-pong source buffer.
package src_buf_pkg;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefLanes = 2;
  localparam int unsigned DefDepth = 1024;

endpackage

// File: rtl/src_bank.sv
// One buffer bank: LANES word arrays written a full beat at a time, read one word
// at a time through a registered port.
module src_bank
  import src_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LANES  = DefLanes,
  parameter int unsigned DEPTH  = DefDepth,
  localparam int unsigned WA_W  = $clog2(DEPTH / LANES),
  localparam int unsigned RA_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [WA_W-1:0]         wa_i,
  input  logic [DATA_W*LANES-1:0] wd_i,
  input  logic                    re_i,
  input  logic [RA_W-1:0]         ra_i,
  output logic [DATA_W-1:0]       rd_o
);

  localparam int unsigned LbW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WA_W-1:0]   row;
  logic [LbW-1:0]    lane;
  logic [LbW-1:0]    lane_q;
  logic [DATA_W-1:0] lane_rd [LANES];

  // Word address splits into array row (upper bits) and lane (lower bits).
  assign row  = WA_W'(ra_i / RA_W'(LANES));
  assign lane = LbW'(ra_i % RA_W'(LANES));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] mem [DEPTH/LANES];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i) mem[wa_i] <= wd_i[i*DATA_W +: DATA_W];
      if (re_i) rd_q <= mem[row];
    end

    assign lane_rd[i] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (re_i) lane_q <= lane;
  end

  if (LANES > 1) begin : g_mux
    assign rd_o = lane_rd[lane_q];
  end else begin : g_single
    assign rd_o = lane_rd[0];
  end

endmodule

// File: rtl/src_pingpong_buf.sv
// Two-bank ping-pong buffer: a producer fills one bank while a consumer reads the other;
// banks hand over with src_last / exec_done.
module src_pingpong_buf
  import src_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LANES  = DefLanes,
  parameter int unsigned DEPTH  = DefDepth,
  localparam int unsigned WA_W  = $clog2(DEPTH / LANES),
  localparam int unsigned RA_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    src_v,
  input  logic [WA_W-1:0]         src_a,
  input  logic [DATA_W*LANES-1:0] src_d,
  input  logic                    src_last,
  output logic                    src_ready,
  output logic                    src_err,
  input  logic                    exec,
  input  logic [RA_W-1:0]         exec_src_addr,
  input  logic                    exec_done,
  output logic                    exec_ready,
  output logic [DATA_W-1:0]       exec_src_data,
  output logic                    exec_src_valid
);

  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic              err_q, err_d;
  logic              valid_q;
  logic              rd_bank_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] bank_rd [2];
  logic              wr_acc;
  logic              rd_acc;

  assign src_ready  = (state_q[wp_q] == FREE);
  assign exec_ready = (state_q[rp_q] == FULL);
  assign wr_acc     = src_v & src_ready;
  assign rd_acc     = exec & exec_ready;

  // src_last and exec_done can never target the same bank, so both updates compose.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    err_d   = err_q | ((src_v | src_last) & ~src_ready);
    if (src_last && src_ready) begin
      state_d[wp_q] = FULL;
      wp_d          = ~wp_q;
    end
    if (exec_done && exec_ready) begin
      state_d[rp_q] = FREE;
      rp_d          = ~rp_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0] <= FREE;
      state_q[1] <= FREE;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      rd_bank_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      err_q      <= err_d;
      valid_q    <= rd_acc;
      rd_bank_q  <= rd_acc ? rp_q : rd_bank_q;
      hold_q     <= exec_src_data;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    src_bank #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk  (clk),
      .we_i (wr_acc & (wp_q == 1'(b))),
      .wa_i (src_a),
      .wd_i (src_d),
      .re_i (rd_acc & (rp_q == 1'(b))),
      .ra_i (exec_src_addr),
      .rd_o (bank_rd[b])
    );
  end

  // RAM outputs carry no reset; hold_q supplies the reset value and the held value.
  assign exec_src_data  = valid_q ? bank_rd[rd_bank_q] : hold_q;
  assign exec_src_valid = valid_q;
  assign src_err        = err_q;

endmodule

// File: doc/src_pingpong_buf.md
SRC_PINGPONG_BUF -- requirements
Module: src_pingpong_buf

Interface
REQ-001 Parameter DATA_W, default 32: width of one source word.
REQ-002 Parameter LANES, default 2 (power of 2, >=1): words carried per write beat.
REQ-003 Parameter DEPTH, default 1024 (power of 2, multiple of LANES): words per bank.
REQ-004 Derived constants: WA_W = log2(DEPTH/LANES), RA_W = log2(DEPTH); bank count fixed at 2.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 src_v  in  1  write strobe for one beat.
REQ-008 src_a  in  WA_W  beat address within current fill bank.
REQ-009 src_d  in  DATA_W*LANES  beat data; lane i = src_d[i*DATA_W +: DATA_W].
REQ-010 src_last  in  1  commit current fill bank as full.
REQ-011 src_ready  out  1  current fill bank is free for writing.
REQ-012 src_err  out  1  sticky: a write or commit arrived while src_ready=0.
REQ-013 exec  in  1  read request.
REQ-014 exec_src_addr  in  RA_W  word address within current read bank.
REQ-015 exec_done  in  1  release current read bank.
REQ-016 exec_ready  out  1  current read bank is full and readable.
REQ-017 exec_src_data  out  DATA_W  registered read data.
REQ-018 exec_src_valid  out  1  exec_src_data updated this cycle.

Function
REQ-019 Each bank SHALL hold state FREE or FULL; fill pointer wp and read pointer rp are 1-bit bank indices.
REQ-020 src_ready SHALL equal (state[wp]==FREE); exec_ready SHALL equal (state[rp]==FULL), both combinational from registers.
REQ-021 src_v & src_ready SHALL write lane i to word src_a*LANES+i of bank wp, all lanes the same cycle.
REQ-022 src_last & src_ready SHALL set state[wp]=FULL and toggle wp; a src_v in that same cycle SHALL be written to the committed bank first.
REQ-023 src_v or src_last with src_ready=0 SHALL be dropped and SHALL set src_err until reset.
REQ-024 exec & exec_ready SHALL return word exec_src_addr of bank rp on exec_src_data one cycle later with exec_src_valid=1 (latency 1).
REQ-025 exec with exec_ready=0 SHALL be ignored: exec_src_valid=0, exec_src_data holds.
REQ-026 exec_done & exec_ready SHALL set state[rp]=FREE and toggle rp; an exec in that same cycle SHALL still read the released bank.
REQ-027 exec_done with exec_ready=0 SHALL be ignored.
REQ-028 src_last and exec_done in the same cycle SHALL both take effect (they always target different banks, since FREE and FULL are exclusive).
REQ-029 exec_src_data SHALL hold its last value when no read is accepted; exec_src_valid is a one-cycle pulse per accepted read.
REQ-030 Buffer contents are never cleared; reading a location never written after reset yields undefined data.

Reset
REQ-031 rst SHALL immediately set both banks FREE, wp=0, rp=0, src_err=0, exec_src_valid=0, exec_src_data=0.
REQ-032 Hence after reset src_ready=1 and exec_ready=0; a fill or read in progress at reset is abandoned.
REQ-033 Memory arrays SHALL NOT be reset.

Structure
REQ-034 Package src_buf_pkg SHALL hold the bank-state enum (FREE, FULL) and default DATA_W/LANES/DEPTH values.
REQ-035 Sub-module src_bank SHALL implement one bank (LANES arrays of DEPTH/LANES words, beat write, registered word read) and be instantiated twice.
REQ-036 Arrays SHALL map to block RAM: no reset, one write and one read port per array.

Verification
REQ-037 Reset, write beats a=0..511 with data {2a+1,2a}, src_last on beat 511 -> src_ready=0 one cycle later only if bank1 FULL, else 1; exec_ready=1; read addr 5 -> 5 next cycle.
REQ-038 Fill bank0 and bank1 without exec_done -> src_ready=0; extra src_v -> dropped, src_err=1 and stays 1.
REQ-039 Read bank0 addr 1023 with exec_done same cycle -> data 1023 next cycle, rp=1, bank0 FREE, src_ready=1.
REQ-040 src_last (bank1) and exec_done (bank0) same cycle -> both FULL/FREE transitions applied, wp=0, rp=1.
REQ-041 exec with exec_ready=0 -> exec_src_valid=0, exec_src_data unchanged.
REQ-042 rst asserted mid-fill with bank0 FULL -> next edge not required; outputs immediately src_ready=1, exec_ready=0, exec_src_data=0.
